insn_dispatch: RTL and testbench
================================

INSN_DISPATCH -- requirements
Module: insn_dispatch

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-003 run  input  1  level enable; 0 stops new fetches, and an in-flight instruction completes.
REQ-004 fetch_start  output  1  one-cycle pulse requesting an instruction word from instruction memory.
REQ-005 fetch_done  input  1  memory completion strobe; fetch_data is valid in the same cycle.
REQ-006 fetch_data  input  32  instruction word from memory.
REQ-007 insn  output  32  latched instruction, stable from DECODE until the next fetch completes.
REQ-008 code  output  32  one-hot opcode class: bit0 LOAD, bit1 STORE, bit2 BRANCH, bit3 JAL, bit4 JALR, bit5 OP, bit6 OP-IMM, bit7 OP-32, bit8 OP-IMM-32, bit9 LUI, bit10 AUIPC; bits 31:11 always 0.
REQ-009 start  output  3  one-hot execution FSM select: 001 ALU, 010 branch/jump, 100 load/store, 000 none.
REQ-010 exec_done  input  1  completion from the selected execution FSM.
REQ-011 illegal  output  1  sticky flag; set on an undecodable opcode.
REQ-012 busy  output  1  1 in any state other than IDLE and TRAP.
REQ-013 retired  output  32  count of instructions completed via exec_done.

Function
REQ-014 The states shall be IDLE, FETCH, WAIT_MEM, DECODE, EXEC and TRAP.
REQ-015 IDLE->FETCH when run=1; otherwise stay in IDLE.
REQ-016 FETCH shall assert fetch_start for exactly one cycle and go to WAIT_MEM.
REQ-017 WAIT_MEM: on fetch_done=1, latch fetch_data into insn and go to DECODE; with no timeout, wait indefinitely.
REQ-018 DECODE (1 cycle) shall compute code and start from insn[6:0]:
- ALU (001): OP 0110011, OP-IMM 0010011, OP-32 0111011, OP-IMM-32 0011011, LUI 0110111, AUIPC 0010111.
- Branch/jump (010): BRANCH 1100011, JAL 1101111, JALR 1100111.
- Load/store (100): LOAD 0000011, STORE 0100011.
- Valid opcode -> EXEC.
REQ-019 An opcode not in REQ-018, or insn[1:0]!=11, shall go to TRAP with illegal=1, code=0 and start=000.
REQ-020 code and start shall be registered; both change only on the DECODE->EXEC transition and are cleared on leaving EXEC.
REQ-021 EXEC shall hold start and code constant at level for the whole state; start is never pulsed.
REQ-022 EXEC: exec_done=1 -> retired+1 (wrap 0xFFFFFFFF->0), clear start/code, then go to FETCH if run=1, else IDLE.
REQ-023 exec_done outside EXEC shall be ignored.
REQ-024 fetch_done outside WAIT_MEM shall be ignored and shall not alter insn.
REQ-025 TRAP shall be exited only by reset; fetch_start=0 and start=000 while in TRAP.
REQ-026 run falling during FETCH, WAIT_MEM, DECODE or EXEC shall not abort; the return to IDLE happens only at the EXEC exit.
REQ-027 Minimum latency from fetch_start to start!=000 is 3 cycles when fetch_done arrives the cycle after fetch_start.
REQ-028 Back-to-back: fetch_start shall assert the cycle after the exec_done cycle when run=1.

Reset
REQ-029 reset_n=0 at a clock edge shall force state=IDLE, fetch_start=0, insn=0, code=0, start=000, illegal=0, busy=0, retired=0, in any state including mid-EXEC or WAIT_MEM.
REQ-030 After reset_n returns high, the first fetch_start shall occur no earlier than one cycle after run is sampled as 1.

Verification
REQ-031 Reset, run=1, fetch_data=0x00A00093 (addi) with fetch_done one cycle after fetch_start -> code=0x40, start=001 held until exec_done, then retired=1.
REQ-032 fetch_data=0x00208463 (beq) -> code=0x4, start=010; fetch_data=0x0000A103 (lw) -> code=0x1, start=100; exec_done delayed 10 cycles -> start stays stable for all 10 cycles.
REQ-033 fetch_data=0xFFFFFFFF -> illegal=1, start=000, no further fetch_start; then reset_n=0 for one edge -> illegal=0, state=IDLE.
REQ-034 run dropped to 0 mid-EXEC -> the instruction completes, retired increments, state goes to IDLE, and fetch_start stays 0.
REQ-035 Spurious exec_done in WAIT_MEM and spurious fetch_done in EXEC -> no state, insn or retired change.
REQ-036 retired preloaded to 0xFFFFFFFF via 2^32-1 completions, or forced by the bench -> the next exec_done wraps it to 0.

Source files
------------

// File: rtl/insn_dispatch.sv
// insn_dispatch: fetch/decode/dispatch sequencer that hands each instruction to an ALU, branch or load/store FSM
module insn_dispatch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  output logic        fetch_start,
  input  logic        fetch_done,
  input  logic [31:0] fetch_data,
  output logic [31:0] insn,
  output logic [31:0] code,
  output logic [2:0]  start,
  input  logic        exec_done,
  output logic        illegal,
  output logic        busy,
  output logic [31:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, DECODE, EXEC, TRAP} state_t;
  state_t      state_q, state_d;
  logic [31:0] insn_q, insn_d, code_q, code_d, retired_q, retired_d, dec_code;
  logic [2:0]  start_q, start_d, dec_start;
  logic        illegal_q, illegal_d, fetch_start_q, busy_q;
  always_comb begin
    dec_code  = '0;
    dec_start = 3'b000;
    case (insn_q[6:0])
      7'b0000011: begin dec_code[0]  = 1'b1; dec_start = 3'b100; end
      7'b0100011: begin dec_code[1]  = 1'b1; dec_start = 3'b100; end
      7'b1100011: begin dec_code[2]  = 1'b1; dec_start = 3'b010; end
      7'b1101111: begin dec_code[3]  = 1'b1; dec_start = 3'b010; end
      7'b1100111: begin dec_code[4]  = 1'b1; dec_start = 3'b010; end
      7'b0110011: begin dec_code[5]  = 1'b1; dec_start = 3'b001; end
      7'b0010011: begin dec_code[6]  = 1'b1; dec_start = 3'b001; end
      7'b0111011: begin dec_code[7]  = 1'b1; dec_start = 3'b001; end
      7'b0011011: begin dec_code[8]  = 1'b1; dec_start = 3'b001; end
      7'b0110111: begin dec_code[9]  = 1'b1; dec_start = 3'b001; end
      7'b0010111: begin dec_code[10] = 1'b1; dec_start = 3'b001; end
      default: ;
    endcase
  end
  always_comb begin
    state_d   = state_q;
    insn_d    = insn_q;
    code_d    = code_q;
    start_d   = start_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    case (state_q)
      IDLE:     state_d = run ? FETCH : IDLE;
      FETCH:    state_d = WAIT_MEM;
      WAIT_MEM: if (fetch_done) begin
        insn_d  = fetch_data;
        state_d = DECODE;
      end
      DECODE: begin
        code_d    = dec_code;
        start_d   = dec_start;
        illegal_d = ~|dec_start;
        state_d   = |dec_start ? EXEC : TRAP;
      end
      EXEC: if (exec_done) begin
        retired_d = retired_q + 32'd1;
        code_d    = '0;
        start_d   = 3'b000;
        state_d   = run ? FETCH : IDLE;
      end
      default: ;
    endcase
  end
  // fetch_start and busy are registered from the next state so they align with the state they describe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      insn_q        <= '0;
      code_q        <= '0;
      start_q       <= 3'b000;
      illegal_q     <= 1'b0;
      retired_q     <= '0;
      fetch_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      insn_q        <= insn_d;
      code_q        <= code_d;
      start_q       <= start_d;
      illegal_q     <= illegal_d;
      retired_q     <= retired_d;
      fetch_start_q <= state_d == FETCH;
      busy_q        <= state_d != IDLE && state_d != TRAP;
    end
  end
  assign fetch_start = fetch_start_q;
  assign insn        = insn_q;
  assign code        = code_q;
  assign start       = start_q;
  assign illegal     = illegal_q;
  assign busy        = busy_q;
  assign retired     = retired_q;
endmodule

// File: tb/tb_insn_dispatch.sv
// tb_insn_dispatch: directed and randomized checks of insn_dispatch against an opcode-table reference model
module tb_insn_dispatch;
  logic        clk = 1'b0, reset_n = 1'b0, run = 1'b0, fetch_done = 1'b0, exec_done = 1'b0;
  logic [31:0] fetch_data = '0;
  logic        fetch_start, illegal, busy;
  logic [31:0] insn, code, retired;
  logic [2:0]  start;
  int          checks = 0, failures = 0;
  logic [31:0] m_retired = '0;
  logic [6:0]  opc_tab [11] = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h33, 7'h13, 7'h3b, 7'h1b, 7'h37, 7'h17};
  always #5 clk = ~clk;
  insn_dispatch dut (
    .clk(clk), .reset_n(reset_n), .run(run), .fetch_start(fetch_start),
    .fetch_done(fetch_done), .fetch_data(fetch_data), .insn(insn), .code(code),
    .start(start), .exec_done(exec_done), .illegal(illegal), .busy(busy), .retired(retired)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  // table index i selects code bit i; entries 0-1 load/store, 2-4 branch/jump, rest ALU
  function automatic void classify(input logic [31:0] w, output logic [31:0] c, output logic [2:0] s);
    c = '0;
    s = 3'b000;
    if (w[1:0] == 2'b11)
      for (int i = 0; i < 11; i++)
        if (w[6:0] == opc_tab[i]) begin
          c = 32'd1 << i;
          s = i < 2 ? 3'b100 : i < 5 ? 3'b010 : 3'b001;
        end
  endfunction
  // entered at a negedge where the FETCH pulse is visible
  task automatic do_insn(input logic [31:0] w, input int fdly, input int edly, input bit run_after, input bit noise);
    logic [31:0] c;
    logic [2:0]  s;
    logic [31:0] prev_insn;
    classify(w, c, s);
    prev_insn = insn;
    chk("fetch_start_pulse", 32'(fetch_start), 32'd1);
    fetch_done = noise;
    fetch_data = $urandom;
    tick;
    fetch_done = 1'b0;
    chk("fetch_start_one_cycle", 32'(fetch_start), 32'd0);
    chk("busy_wait_mem", 32'(busy), 32'd1);
    chk("insn_no_early_latch", insn, prev_insn);
    for (int i = 0; i < fdly; i++) begin
      exec_done = noise && ($urandom_range(0, 1) == 1);
      tick;
      chk("retired_spurious_exec_done", retired, m_retired);
      chk("start_wait_mem", 32'(start), 32'd0);
    end
    exec_done  = 1'b0;
    fetch_done = 1'b1;
    fetch_data = w;
    tick;
    fetch_done = 1'b0;
    fetch_data = $urandom;
    chk("insn_latch", insn, w);
    chk("start_decode", 32'(start), 32'd0);
    tick;
    if (s == 3'b000) begin
      chk("trap_illegal", 32'(illegal), 32'd1);
      chk("trap_start", 32'(start), 32'd0);
      chk("trap_code", code, 32'd0);
      chk("trap_busy", 32'(busy), 32'd0);
      return;
    end
    chk("exec_code", code, c);
    chk("exec_start", 32'(start), 32'(s));
    chk("exec_busy", 32'(busy), 32'd1);
    for (int i = 0; i < edly; i++) begin
      if (!run_after) run = 1'b0;
      fetch_done = noise;
      fetch_data = $urandom;
      tick;
      chk("exec_start_hold", 32'(start), 32'(s));
      chk("exec_code_hold", code, c);
      chk("exec_insn_hold", insn, w);
      chk("exec_retired_hold", retired, m_retired);
      chk("exec_no_fetch", 32'(fetch_start), 32'd0);
    end
    fetch_done = 1'b0;
    run        = run_after;
    exec_done  = 1'b1;
    tick;
    exec_done  = 1'b0;
    m_retired  = m_retired + 32'd1;
    chk("retired_inc", retired, m_retired);
    chk("exit_start_clear", 32'(start), 32'd0);
    chk("exit_code_clear", code, 32'd0);
    chk("exit_fetch_start", 32'(fetch_start), 32'(run_after));
    chk("exit_busy", 32'(busy), 32'(run_after));
  endtask
  initial begin
    logic [31:0] r;
    tick;
    tick;
    chk("rst_fetch_start", 32'(fetch_start), 32'd0);
    chk("rst_insn", insn, 32'd0);
    chk("rst_code", code, 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_retired", retired, 32'd0);
    reset_n = 1'b1;
    tick;
    chk("idle_no_fetch", 32'(fetch_start), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    run = 1'b1;
    tick;
    do_insn(32'h00A00093, 0, 2, 1'b1, 1'b0);
    chk("addi_retired_one", retired, 32'd1);
    do_insn(32'h00208463, 0, 1, 1'b1, 1'b0);
    do_insn(32'h0000A103, 0, 10, 1'b1, 1'b1);
    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      do_insn({r[31:7], opc_tab[$urandom_range(0, 10)]}, $urandom_range(0, 3), $urandom_range(0, 4), 1'b1, 1'b1);
    end
    do_insn(32'h00500113, 1, 3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("run_drop_idle_no_fetch", 32'(fetch_start), 32'd0);
      chk("run_drop_idle_busy", 32'(busy), 32'd0);
    end
    force dut.retired_q = 32'hFFFFFFFF;
    tick;
    release dut.retired_q;
    tick;
    m_retired = 32'hFFFFFFFF;
    chk("retired_preload", retired, m_retired);
    run = 1'b1;
    tick;
    do_insn(32'h00000037, 0, 0, 1'b1, 1'b0);
    chk("retired_wrap_zero", retired, 32'd0);
    do_insn(32'hFFFFFFFF, 1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      fetch_done = 1'b1;
      exec_done  = 1'b1;
      fetch_data = $urandom;
      tick;
      chk("trap_no_fetch", 32'(fetch_start), 32'd0);
      chk("trap_sticky", 32'(illegal), 32'd1);
      chk("trap_start_zero", 32'(start), 32'd0);
      chk("trap_insn_hold", insn, 32'hFFFFFFFF);
    end
    fetch_done = 1'b0;
    exec_done  = 1'b0;
    reset_n    = 1'b0;
    tick;
    reset_n    = 1'b1;
    m_retired  = '0;
    chk("trap_reset_illegal", 32'(illegal), 32'd0);
    chk("trap_reset_busy", 32'(busy), 32'd0);
    chk("trap_reset_insn", insn, 32'd0);
    chk("trap_reset_fetch_start", 32'(fetch_start), 32'd0);
    tick;
    do_insn(32'h00000010, 0, 0, 1'b1, 1'b0);
    tick;
    chk("low_bits_trap_no_fetch", 32'(fetch_start), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
